// File: rtl/instr_loader.sv
// instr_loader
//
// Pulls a stream of instruction words from the upstream transmitter into a
// local buffer. Each word is requested with a one-cycle l_o_syn pulse and
// captured when the transmitter answers with l_i_ack. Loading ends when the
// transmitter flags the final word. After that, the fetch stage reads the
// buffer through a registered read port. A missing acknowledge or a stream
// longer than the buffer parks the block in a sticky error state. Only a new
// start pulse or reset leaves that state.
//
// Ports
//   t_clk      rising-edge clock
//   t_rst      asynchronous reset, active low
//   l_i_start  begin or restart a load; honoured in IDLE, DONE and ERR
//   l_o_syn    one-cycle request pulse to the transmitter
//   l_i_instr  instruction word from the transmitter
//   l_i_ack    transmitter word valid
//   l_i_last   transmitter final-word flag, qualified by l_i_ack
//   l_i_raddr  fetch read address
//   l_o_rdata  fetch read data, one cycle after the address
//   l_o_ready  buffer fully loaded
//   l_o_count  number of words stored by the current or most recent load
//   l_o_err    sticky error (ack timeout or overlong stream)

module instr_loader #(
  parameter int IWIDTH  = 32,
  parameter int DEPTH   = 36,
  parameter int AWIDTH  = 6,
  parameter int TIMEOUT = 15
) (
  input  logic              t_clk,
  input  logic              t_rst,
  input  logic              l_i_start,
  output logic              l_o_syn,
  input  logic [IWIDTH-1:0] l_i_instr,
  input  logic              l_i_ack,
  input  logic              l_i_last,
  input  logic [AWIDTH-1:0] l_i_raddr,
  output logic [IWIDTH-1:0] l_o_rdata,
  output logic              l_o_ready,
  output logic [AWIDTH-1:0] l_o_count,
  output logic              l_o_err
);

  // The wait timer only counts up to TIMEOUT-1, so it needs clog2(TIMEOUT)
  // bits. A minimum width of one bit keeps TIMEOUT=1 legal.
  localparam int TWIDTH = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [TWIDTH-1:0] TIMER_MAX = TWIDTH'(TIMEOUT - 1);
  localparam logic [AWIDTH-1:0] LAST_SLOT = AWIDTH'(DEPTH - 1);
  localparam logic [AWIDTH-1:0] DEPTH_A   = AWIDTH'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    ERR
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [AWIDTH-1:0] count_q;
  logic [AWIDTH-1:0] count_d;
  logic [TWIDTH-1:0] timer_q;
  logic [TWIDTH-1:0] timer_d;
  logic              mem_we;

  logic [IWIDTH-1:0] mem [DEPTH];

  // State, word count and ack timer. These are the only registers that reset
  // clears, apart from the read data. A reset in the middle of a load
  // abandons it, and the block then waits in IDLE for a fresh start.
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic for the handshake.
  // REQ lasts exactly one cycle and is always followed by WAIT. This means
  // the request line can never stay high for two cycles in a row, so the
  // transmitter advances exactly once per request.
  // In WAIT, the timer holds the number of ack-less cycles seen so far. The
  // block gives up on the cycle the timer already reads TIMEOUT-1, which
  // allows TIMEOUT cycles for the answer in total.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        count_d = '0;
        timer_d = '0;
        if (l_i_start) begin
          state_d = REQ;
        end
      end

      REQ: begin
        state_d = WAIT;
        timer_d = '0;
      end

      WAIT: begin
        if (l_i_ack) begin
          mem_we  = 1'b1;
          count_d = count_q + AWIDTH'(1);
          if (l_i_last) begin
            state_d = DONE;
          end else if (count_q == LAST_SLOT) begin
            // The final slot was just filled and the stream still has not
            // ended. Treat this as an overflow and do not ask for more.
            state_d = ERR;
          end else begin
            state_d = REQ;
          end
        end else if (timer_q == TIMER_MAX) begin
          state_d = ERR;
        end else begin
          timer_d = timer_q + TWIDTH'(1);
        end
      end

      DONE, ERR: begin
        if (l_i_start) begin
          state_d = REQ;
          count_d = '0;
          timer_d = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Instruction buffer write port. It has no reset on purpose: a restart only
  // rewinds the count. Entries at or above the count keep whatever an
  // earlier load left in them.
  always_ff @(posedge t_clk) begin
    if (mem_we) begin
      mem[count_q] <= l_i_instr;
    end
  end

  // Registered fetch read port. It runs in every state. Because the write
  // uses a non-blocking assignment, a read of the slot being written on the
  // same edge returns the previous contents. Addresses beyond the buffer
  // read as zero.
  always_ff @(posedge t_clk or negedge t_rst) begin
    if (!t_rst) begin
      l_o_rdata <= '0;
    end else if (l_i_raddr < DEPTH_A) begin
      l_o_rdata <= mem[l_i_raddr];
    end else begin
      l_o_rdata <= '0;
    end
  end

  assign l_o_syn   = (state_q == REQ);
  assign l_o_ready = (state_q == DONE);
  assign l_o_err   = (state_q == ERR);
  assign l_o_count = count_q;

endmodule
